// File: rtl/tron_pkg.sv
// Shared types and constants for the Tron game core: game-state encoding,
// scorer FSM states and the default "no collision" head colour.
package tron_pkg;

    typedef enum logic [2:0] {
        PLAY      = 3'd1,
        GAME_OVER = 3'd4
    } game_state_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PLAY       = 2'd1,
        ST_ROUND_DONE = 2'd2,
        ST_MATCH_DONE = 2'd3
    } scorer_state_t;

    localparam logic [7:0] SAFE_COLOR_DEFAULT = 8'd1;

endpackage

// File: rtl/tron_match_scorer_bcd.sv
// Registered binary to two-digit BCD converter for the score display.
// Inputs above 99 show as 8'h99.
module score_bcd #(
    parameter int IN_W = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [IN_W-1:0] i_bin,
    output logic [7:0]      o_bcd
);

    int unsigned w_val;
    logic [3:0]  w_tens;
    logic [3:0]  w_ones;
    logic [7:0]  w_bcd;

    always_comb begin
        w_val  = 32'(i_bin);
        w_tens = 4'(w_val / 10);
        w_ones = 4'(w_val % 10);
        w_bcd  = {w_tens, w_ones};
        if (w_val > 99) begin
            w_bcd = 8'h99;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_bcd <= 8'h00;
        end else begin
            o_bcd <= w_bcd;
        end
    end

endmodule

// File: rtl/tron_match_scorer.sv
// N-player round/match scorer driven by a synchronised frame tick.
// Optional TRON_SCORE_BCD_EN adds a registered per-player BCD score output.
module tron_match_scorer
    import tron_pkg::*;
#(
    parameter int                 NUM_PLAYERS = 2,
    parameter int                 COLOR_W     = 8,
    parameter logic [COLOR_W-1:0] SAFE_COLOR  = COLOR_W'(SAFE_COLOR_DEFAULT),
    parameter int                 SCORE_W     = 4,
    parameter int                 WIN_SCORE   = 3
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           frame_clk,
    input  logic                           Reset_Score,
    input  logic [2:0]                     Game_State,
    input  logic [NUM_PLAYERS*COLOR_W-1:0] head_color,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score,
    output logic                           round_over,
    output logic [NUM_PLAYERS-1:0]         round_winner,
    output logic                           match_over,
`ifdef TRON_SCORE_BCD_EN
    output logic [NUM_PLAYERS*8-1:0]       score_bcd,
`endif
    output logic [NUM_PLAYERS-1:0]         match_winner
);

    scorer_state_t r_state;
    scorer_state_t w_state_next;

    logic r_sync1;
    logic r_sync2;
    logic r_hist;
    logic w_tick;
    logic w_play;

    logic [NUM_PLAYERS-1:0]              w_crash;
    logic [NUM_PLAYERS-1:0]              w_hit;
    logic [NUM_PLAYERS-1:0][SCORE_W-1:0] r_score;
    logic [NUM_PLAYERS-1:0][SCORE_W-1:0] w_score_next;
    logic                                r_round_over;
    logic                                w_round_over_next;
    logic [NUM_PLAYERS-1:0]              r_round_winner;
    logic [NUM_PLAYERS-1:0]              w_round_winner_next;
    logic                                r_match_over;
    logic                                w_match_over_next;
    logic [NUM_PLAYERS-1:0]              r_match_winner;
    logic [NUM_PLAYERS-1:0]              w_match_winner_next;

    // frame_clk is asynchronous; only Reset clears the synchroniser chain
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
        end else begin
            r_sync1 <= frame_clk;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign w_tick = r_sync2 & ~r_hist;
    assign w_play = (Game_State == PLAY);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_crash
            assign w_crash[gi] = (head_color[gi*COLOR_W +: COLOR_W] != SAFE_COLOR);
        end
    endgenerate

    always_comb begin
        w_state_next        = r_state;
        w_score_next        = r_score;
        w_round_over_next   = 1'b0;
        w_round_winner_next = r_round_winner;
        w_match_over_next   = r_match_over;
        w_match_winner_next = r_match_winner;
        w_hit               = '0;

        if (Reset_Score) begin
            w_state_next        = ST_IDLE;
            w_score_next        = '0;
            w_round_winner_next = '0;
            w_match_over_next   = 1'b0;
            w_match_winner_next = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_play) begin
                        w_state_next = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (!w_play) begin
                        w_state_next = ST_IDLE;
                    end else if (w_tick && (|w_crash)) begin
                        for (int p = 0; p < NUM_PLAYERS; p++) begin
                            if (!w_crash[p] && (w_score_next[p] != '1)) begin
                                w_score_next[p] = w_score_next[p] + 1'b1;
                            end
                            w_hit[p] = (WIN_SCORE != 0) &&
                                       (32'(w_score_next[p]) >= 32'(WIN_SCORE));
                        end
                        w_round_winner_next = ~w_crash;
                        w_round_over_next   = 1'b1;
                        if (|w_hit) begin
                            w_match_over_next   = 1'b1;
                            w_match_winner_next = w_hit;
                            w_state_next        = ST_MATCH_DONE;
                        end else begin
                            w_state_next = ST_ROUND_DONE;
                        end
                    end
                end
                ST_ROUND_DONE: begin
                    if (!w_play) begin
                        w_state_next = ST_IDLE;
                    end
                end
                ST_MATCH_DONE: begin
                    w_state_next = ST_MATCH_DONE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state        <= ST_IDLE;
            r_score        <= '0;
            r_round_over   <= 1'b0;
            r_round_winner <= '0;
            r_match_over   <= 1'b0;
            r_match_winner <= '0;
        end else begin
            r_state        <= w_state_next;
            r_score        <= w_score_next;
            r_round_over   <= w_round_over_next;
            r_round_winner <= w_round_winner_next;
            r_match_over   <= w_match_over_next;
            r_match_winner <= w_match_winner_next;
        end
    end

    assign score        = r_score;
    assign round_over   = r_round_over;
    assign round_winner = r_round_winner;
    assign match_over   = r_match_over;
    assign match_winner = r_match_winner;

`ifdef TRON_SCORE_BCD_EN
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_bcd
            score_bcd #(
                .IN_W (SCORE_W)
            ) u_score_bcd (
                .i_clk (Clk),
                .i_rst (Reset),
                .i_bin (r_score[gi]),
                .o_bcd (score_bcd[gi*8 +: 8])
            );
        end
    endgenerate
`endif

endmodule

// File: tb/tb_tron_match_scorer.sv
// Directed bench: dut uses WIN_SCORE=3, dut0 uses WIN_SCORE=0 for long-run
// saturation (and BCD when TRON_SCORE_BCD_EN is defined).
module tb_tron_match_scorer;
    import tron_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic        Reset_Score = 1'b0;
    logic [2:0]  Game_State = 3'd0;
    logic [15:0] head_color = {8'd1, 8'd1};
    logic [15:0] head_color0 = {8'd1, 8'd1};

    logic [7:0]  score, score0;
    logic        ro, ro0;
    logic [1:0]  rw, rw0;
    logic        mo, mo0;
    logic [1:0]  mw, mw0;
`ifdef TRON_SCORE_BCD_EN
    logic [15:0] bcd, bcd0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    tron_match_scorer #(.WIN_SCORE(3)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .Reset_Score  (Reset_Score),
        .Game_State   (Game_State),
        .head_color   (head_color),
        .score        (score),
        .round_over   (ro),
        .round_winner (rw),
        .match_over   (mo),
`ifdef TRON_SCORE_BCD_EN
        .score_bcd    (bcd),
`endif
        .match_winner (mw)
    );

    tron_match_scorer #(.WIN_SCORE(0)) dut0 (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .Reset_Score  (Reset_Score),
        .Game_State   (Game_State),
        .head_color   (head_color0),
        .score        (score0),
        .round_over   (ro0),
        .round_winner (rw0),
        .match_over   (mo0),
`ifdef TRON_SCORE_BCD_EN
        .score_bcd    (bcd0),
`endif
        .match_winner (mw0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame pulse (4 Clk high, >=3 Clk low); records round_over on the
    // cycles after edges k..k+3 and expects a pulse only after edge k+2.
    task automatic frame(input bit sel, input logic exp_pulse, input string tag);
        logic a, b, c, d;
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) a = sel ? ro0 : ro;
        @(negedge Clk) b = sel ? ro0 : ro;
        @(negedge Clk) c = sel ? ro0 : ro;
        @(negedge Clk) d = sel ? ro0 : ro;
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        chk(tag, {28'd0, a, b, c, d}, {28'd0, 1'b0, 1'b0, exp_pulse, 1'b0});
    endtask

    task automatic gs_cycle();
        @(negedge Clk) Game_State = 3'd0;
        repeat (2) @(negedge Clk);
        Game_State = 3'd1;
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        $display("tb_tron_match_scorer start");
        repeat (3) @(negedge Clk);
        chk("reset_score", {24'd0, score}, 32'h0);
        chk("reset_ro", {31'd0, ro}, 32'h0);
        chk("reset_rw", {30'd0, rw}, 32'h0);
        chk("reset_mo_mw", {29'd0, mo, mw}, 32'h0);
        Reset = 1'b0;

        // Round 1: player 0 crashes
        @(negedge Clk) Game_State = 3'd1;
        head_color = {8'd1, 8'd0};
        repeat (2) @(negedge Clk);
        frame(1'b0, 1'b1, "r1_pulse");
        chk("r1_score", {24'd0, score}, 32'h10);
        chk("r1_rw", {30'd0, rw}, 32'h2);
        $display("round1 score=%h rw=%b", score, rw);

        // Crash held for two more frames: scored once only
        frame(1'b0, 1'b0, "held_f2_pulse");
        frame(1'b0, 1'b0, "held_f3_pulse");
        chk("held_score", {24'd0, score}, 32'h10);

        gs_cycle();
        frame(1'b0, 1'b1, "r2_pulse");
        chk("r2_score", {24'd0, score}, 32'h20);
        $display("round2 score=%h", score);

        // Draw
        gs_cycle();
        head_color = {8'd0, 8'd0};
        frame(1'b0, 1'b1, "draw_pulse");
        chk("draw_score", {24'd0, score}, 32'h20);
        chk("draw_rw", {30'd0, rw}, 32'h0);
        chk("draw_mo", {31'd0, mo}, 32'h0);

        // Third p1 point ends the match
        gs_cycle();
        head_color = {8'd1, 8'd0};
        frame(1'b0, 1'b1, "r3_pulse");
        chk("r3_score", {24'd0, score}, 32'h30);
        chk("r3_mo", {31'd0, mo}, 32'h1);
        chk("r3_mw", {30'd0, mw}, 32'h2);
        $display("match score=%h mo=%b mw=%b", score, mo, mw);

        // Match over: further crashes ignored
        gs_cycle();
        head_color = {8'd0, 8'd1};
        frame(1'b0, 1'b0, "post_match_pulse");
        chk("post_match_score", {24'd0, score}, 32'h30);
        chk("post_match_mo", {31'd0, mo}, 32'h1);

        @(negedge Clk) Reset_Score = 1'b1;
        @(negedge Clk) Reset_Score = 1'b0;
        chk("rs_score", {24'd0, score}, 32'h0);
        chk("rs_flags", {26'd0, ro, rw, mo, mw}, 32'h0);
        chk("rs_state", {30'd0, dut.r_state}, {30'd0, ST_IDLE});
        $display("reset_score state=%0d", dut.r_state);

        // Crash while GAME_OVER: nothing happens
        Game_State = 3'd4;
        head_color = {8'd1, 8'd0};
        frame(1'b0, 1'b0, "gameover_pulse");
        chk("gameover_score", {24'd0, score}, 32'h0);
        chk("gameover_state", {30'd0, dut.r_state}, {30'd0, ST_IDLE});

        // Safe frame in PLAY, then a scored round, then async Reset
        Game_State = 3'd1;
        head_color = {8'd1, 8'd1};
        repeat (2) @(negedge Clk);
        frame(1'b0, 1'b0, "safe_pulse");
        chk("safe_score", {24'd0, score}, 32'h0);
        head_color = {8'd1, 8'd0};
        frame(1'b0, 1'b1, "pre_rst_pulse");
        chk("pre_rst_score", {24'd0, score}, 32'h10);
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        chk("async_rst_score", {24'd0, score}, 32'h0);
        chk("async_rst_rw", {30'd0, rw}, 32'h0);
        $display("async reset score=%h", score);
        @(negedge Clk) Reset = 1'b0;
        head_color = {8'd1, 8'd1};

        // WIN_SCORE=0 instance: 20 rounds, p1 saturates at 15
        head_color0 = {8'd1, 8'd0};
        for (int r = 1; r <= 20; r++) begin
            gs_cycle();
            frame(1'b1, 1'b1, "w0_round_pulse");
            $display("w0 round %0d score0=%h", r, score0);
            if (r == 12) begin
                chk("w0_r12_score", {24'd0, score0}, 32'hC0);
`ifdef TRON_SCORE_BCD_EN
                chk("w0_r12_bcd", {16'd0, bcd0}, 32'h1200);
`endif
            end
        end
        chk("w0_r20_score", {24'd0, score0}, 32'hF0);
        chk("w0_r20_mo", {31'd0, mo0}, 32'h0);
        chk("w0_r20_rw", {30'd0, rw0}, 32'h2);
`ifdef TRON_SCORE_BCD_EN
        chk("w0_r20_bcd", {16'd0, bcd0}, 32'h1500);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
